// File: rtl/text_overlay_render.sv
// text_overlay_render
// Draws NUM_LINES text lines over the VGA pixel stream. Each line has its own
// origin, power-of-two scale, RGB565 colour and blink enable. Characters are
// held in an internal RAM that is swept to spaces after reset. Glyph rows come
// from an external registered ROM. Pixel latency is a fixed 3 cycles with no
// stalls:
//   N   : hit test on screen_x/screen_y
//   N+1 : char RAM read -> glyph_code/glyph_row
//   N+2 : glyph_bits arrive from the ROM
//   N+3 : pix_data
// The write port has no back-pressure. Every cycle in which wr_en is high
// while the block is in RUN commits exactly one write. Writes made while busy
// is high are dropped.
module text_overlay_render #(
    parameter int          NUM_LINES    = 2,
    parameter int          MAX_CHARS    = 16,
    parameter int          GLYPH_W      = 16,
    parameter int          GLYPH_H      = 16,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [15:0] BG_COLOUR    = 16'h0000,
    localparam int         LW           = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
    localparam int         CW           = $clog2(MAX_CHARS),
    localparam int         RW           = $clog2(GLYPH_H)
) (
    input  logic                    vga_clk,
    input  logic                    sys_rst_n,
    input  logic [9:0]              screen_x,
    input  logic [9:0]              screen_y,
    input  logic                    frame_start,
    input  logic [NUM_LINES*10-1:0] line_x,
    input  logic [NUM_LINES*10-1:0] line_y,
    input  logic [NUM_LINES*2-1:0]  line_scale,
    input  logic [NUM_LINES*16-1:0] line_colour,
    input  logic [NUM_LINES-1:0]    line_blink,
    input  logic                    wr_en,
    input  logic [LW-1:0]           wr_line,
    input  logic [CW-1:0]           wr_col,
    input  logic [4:0]              wr_char,
    output logic                    busy,
    output logic [4:0]              glyph_code,
    output logic [RW-1:0]           glyph_row,
    input  logic [GLYPH_W-1:0]      glyph_bits,
    output logic [15:0]             pix_data,
    output logic                    state_dbg
);

    localparam int XW    = $clog2(GLYPH_W);
    localparam int AW    = LW + CW;
    localparam int DEPTH = NUM_LINES * MAX_CHARS;
    // Box arithmetic is done this wide so that a right or bottom edge past
    // 1023 never wraps back onto the screen.
    localparam int EW    = 24;
    localparam int BCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [AW-1:0]  LAST_ADDR   = AW'(DEPTH - 1);
    localparam logic [BCW-1:0] LAST_BLINK  = BCW'(BLINK_FRAMES - 1);
    localparam logic [LW:0]    LINES_W     = (LW + 1)'(NUM_LINES);
    localparam logic [4:0]     CH_SPACE    = 5'd26;
    localparam logic [4:0]     CH_LAST_VIS = 5'd25;
    localparam logic [XW-1:0]  PX_MSB      = XW'(GLYPH_W - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic            clr_we;
    logic            run;

    // The RAM is addressed as {line, col}. Because MAX_CHARS is a power of
    // two, the linear clear sweep 0..DEPTH-1 covers exactly every valid
    // {line, col}.
    logic [4:0]      char_ram [2**AW];
    logic [LW:0]     wr_line_ext;
    logic            user_we;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;

    logic [BCW-1:0]  blink_cnt;
    logic            blink_hidden;

    logic [EW-1:0]   px_x, px_y, lx, ly, box_w, box_h, sx, sy;
    logic [1:0]      sc;
    logic            hit, hit_v, hit_blink;
    logic [LW-1:0]   hit_line;
    logic [CW-1:0]   hit_col;
    logic [XW-1:0]   hit_px;
    logic [RW-1:0]   hit_row;
    logic [15:0]     hit_colour;

    logic            s1_hit, s1_hide;
    logic [XW-1:0]   s1_px;
    logic [15:0]     s1_colour;
    logic            s2_hit, s2_hide, s2_draw;
    logic [XW-1:0]   s2_px;
    logic [15:0]     s2_colour;

    assign run       = (state_q == ST_RUN);
    assign busy      = (state_q == ST_CLEAR);
    assign state_dbg = run;

    // State register for the clear sweep / run controller.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next state: sweep one RAM address per cycle, then run forever.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    clr_addr_d = '0;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CLEAR;
        endcase
    end

    // Writes to lines that do not exist are dropped rather than aliased.
    assign wr_line_ext = {1'b0, wr_line};
    assign user_we     = wr_en && run && (wr_line_ext < LINES_W);
    assign wr_addr     = {wr_line, wr_col};
    assign rd_addr     = {hit_line, hit_col};

    // Char RAM write port. The clear sweep owns the port until RUN.
    always_ff @(posedge vga_clk) begin
        if (clr_we) begin
            char_ram[clr_addr_q] <= CH_SPACE;
        end else if (user_we) begin
            char_ram[wr_addr] <= wr_char;
        end
    end

    // Blink phase advances only on frame_start, so a frame never tears.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt == LAST_BLINK) begin
                blink_cnt    <= '0;
                blink_hidden <= ~blink_hidden;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Hit test. Lines are scanned from highest to lowest index, so the lowest
    // index that contains the pixel is the one that ends up selected.
    always_comb begin
        hit        = 1'b0;
        hit_line   = '0;
        hit_col    = '0;
        hit_px     = '0;
        hit_row    = '0;
        hit_colour = BG_COLOUR;
        hit_blink  = 1'b0;
        px_x       = EW'(screen_x);
        px_y       = EW'(screen_y);
        lx         = '0;
        ly         = '0;
        sc         = '0;
        box_w      = '0;
        box_h      = '0;
        sx         = '0;
        sy         = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            lx    = EW'(line_x[10*i +: 10]);
            ly    = EW'(line_y[10*i +: 10]);
            sc    = line_scale[2*i +: 2];
            box_w = EW'(MAX_CHARS * GLYPH_W) << sc;
            box_h = EW'(GLYPH_H) << sc;
            if (px_x >= lx && px_x < lx + box_w && px_y >= ly && px_y < ly + box_h) begin
                sx         = (px_x - lx) >> sc;
                sy         = (px_y - ly) >> sc;
                hit        = 1'b1;
                hit_line   = LW'(i);
                hit_col    = CW'(sx >> XW);
                hit_px     = XW'(sx);
                hit_row    = RW'(sy);
                hit_colour = line_colour[16*i +: 16];
                hit_blink  = line_blink[i];
            end
        end
    end

    // No foreground is drawn while the RAM is still being cleared.
    assign hit_v = hit && run;

    // Stage 1: registered char RAM read drives the ROM address.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            glyph_code <= CH_SPACE;
            glyph_row  <= '0;
            s1_hit     <= 1'b0;
            s1_px      <= '0;
            s1_colour  <= BG_COLOUR;
            s1_hide    <= 1'b0;
        end else begin
            glyph_code <= hit_v ? char_ram[rd_addr] : CH_SPACE;
            glyph_row  <= hit_v ? hit_row : '0;
            s1_hit     <= hit_v;
            s1_px      <= hit_px;
            s1_colour  <= hit_colour;
            s1_hide    <= hit_blink && blink_hidden;
        end
    end

    // Stage 2: wait for the ROM. Decide here whether the code is a drawable
    // letter; space and blank codes never draw foreground.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s2_hit    <= 1'b0;
            s2_draw   <= 1'b0;
            s2_px     <= '0;
            s2_colour <= BG_COLOUR;
            s2_hide   <= 1'b0;
        end else begin
            s2_hit    <= s1_hit;
            s2_draw   <= (glyph_code <= CH_LAST_VIS);
            s2_px     <= s1_px;
            s2_colour <= s1_colour;
            s2_hide   <= s1_hide;
        end
    end

    // Stage 3: select the glyph bit (MSB is the leftmost pixel) and register
    // the output pixel.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data <= '0;
        end else if (s2_hit && s2_draw && !s2_hide && glyph_bits[PX_MSB - s2_px]) begin
            pix_data <= s2_colour;
        end else begin
            pix_data <= BG_COLOUR;
        end
    end

endmodule
